// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared types for the AHB-Lite instruction/data bus merge: data-phase owner,
// transfer-type encodings and the captured address-phase payload.
package p_hardisc;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} ahb_owner_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [5:0]  parity;
  } ahb_aphase_t;

endpackage

// File: rtl/ahb_bus_arbiter_pend.sv
// One-deep holding slot for an address phase that lost arbitration or arrived
// during downstream wait states; the captured transfer stays until granted.
module ahb_pend_slot
  import p_hardisc::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_i,
  input  logic        clear_i,
  input  ahb_aphase_t aphase_i,
  output logic        valid_o,
  output ahb_aphase_t aphase_o
);

  logic        valid_d, valid_q;
  ahb_aphase_t aphase_q;

  always_comb begin
    valid_d = valid_q;
    if (clear_i)        valid_d = 1'b0;
    else if (capture_i) valid_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // NOTE: the payload is deliberately left without reset; it is only ever observed while valid_q is set.
  always_ff @(posedge clk) begin
    if (capture_i) aphase_q <= aphase_i;
  end

  assign valid_o  = valid_q;
  assign aphase_o = aphase_q;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Two-to-one AHB-Lite arbiter merging the instruction and load/store masters onto
// one master port; the losing address phase is parked and its master stalled.
module ahb_bus_arbiter
  import p_hardisc::*;
#(
  parameter bit RR_ARB = 1'b1
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,

  input  logic [31:0] s_i_haddr_i,
  input  logic [1:0]  s_i_htrans_i,
  input  logic [2:0]  s_i_hsize_i,
  input  logic        s_i_hwrite_i,
  input  logic [5:0]  s_i_hparity_i,

  input  logic [31:0] s_d_haddr_i,
  input  logic [1:0]  s_d_htrans_i,
  input  logic [2:0]  s_d_hsize_i,
  input  logic        s_d_hwrite_i,
  input  logic [5:0]  s_d_hparity_i,
  input  logic [31:0] s_d_hwdata_i,
  input  logic [6:0]  s_d_hwchecksum_i,

  output logic        s_i_hready_o,
  output logic        s_i_hresp_o,
  output logic        s_d_hready_o,
  output logic        s_d_hresp_o,
  output logic [31:0] s_hrdata_o,
  output logic [6:0]  s_hrchecksum_o,

  output logic [31:0] s_haddr_o,
  output logic [1:0]  s_htrans_o,
  output logic [2:0]  s_hsize_o,
  output logic        s_hwrite_o,
  output logic [5:0]  s_hparity_o,
  output logic [31:0] s_hwdata_o,
  output logic [6:0]  s_hwchecksum_o,

  input  logic [31:0] s_hrdata_i,
  input  logic [6:0]  s_hrchecksum_i,
  input  logic        s_hready_i,
  input  logic        s_hresp_i
);

  ahb_aphase_t i_live, d_live, i_slot, d_slot, i_sel, d_sel, gnt_sel;
  ahb_aphase_t hold_d, hold_q;
  ahb_owner_t  owner_d, owner_q, last_d, last_q;
  logic        i_valid, d_valid;
  logic        i_rdy, d_rdy;
  logic        i_fresh, d_fresh, i_req, d_req;
  logic        gnt_i, gnt_d;

  // Only htrans[1] matters: SEQ folds into NONSEQ and BUSY into IDLE.
  logic unused_htrans;
  assign unused_htrans = s_i_htrans_i[0] ^ s_d_htrans_i[0];

  assign i_live = '{addr: s_i_haddr_i, size: s_i_hsize_i, write: s_i_hwrite_i, parity: s_i_hparity_i};
  assign d_live = '{addr: s_d_haddr_i, size: s_d_hsize_i, write: s_d_hwrite_i, parity: s_d_hparity_i};

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    i_rdy = 1'b1;
    if (i_valid)                i_rdy = 1'b0;
    else if (owner_q == OWN_I)  i_rdy = s_hready_i;
    d_rdy = 1'b1;
    if (d_valid)                d_rdy = 1'b0;
    else if (owner_q == OWN_D)  d_rdy = s_hready_i;

    i_fresh = s_i_htrans_i[1] & i_rdy;
    d_fresh = s_d_htrans_i[1] & d_rdy;
    i_req   = i_fresh | i_valid;
    d_req   = d_fresh | d_valid;

    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (s_hready_i) begin
      if (i_req && d_req) begin
        if (RR_ARB && (last_q == OWN_D)) gnt_i = 1'b1;
        else                             gnt_d = 1'b1;
      end else begin
        gnt_i = i_req;
        gnt_d = d_req;
      end
    end

    i_sel   = i_valid ? i_slot : i_live;
    d_sel   = d_valid ? d_slot : d_live;
    gnt_sel = gnt_d ? d_sel : i_sel;

    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (s_hready_i) begin
      owner_d = gnt_d ? OWN_D : (gnt_i ? OWN_I : OWN_NONE);
      if (gnt_i || gnt_d) begin
        last_d = gnt_d ? OWN_D : OWN_I;
        hold_d = gnt_sel;
      end
    end
  end

  ahb_pend_slot u_slot_i (
    .clk       (s_clk_i),
    .rst_n     (s_resetn_i),
    .capture_i (i_fresh & ~gnt_i),
    .clear_i   (gnt_i & i_valid),
    .aphase_i  (i_live),
    .valid_o   (i_valid),
    .aphase_o  (i_slot)
  );

  ahb_pend_slot u_slot_d (
    .clk       (s_clk_i),
    .rst_n     (s_resetn_i),
    .capture_i (d_fresh & ~gnt_d),
    .clear_i   (gnt_d & d_valid),
    .aphase_i  (d_live),
    .valid_o   (d_valid),
    .aphase_o  (d_slot)
  );

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      owner_q <= OWN_NONE;
      last_q  <= OWN_I;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Address fields park on the last issued transfer whenever nothing is granted.
  always_comb begin
    if (gnt_i || gnt_d) begin
      s_htrans_o  = HTRANS_NONSEQ;
      s_haddr_o   = gnt_sel.addr;
      s_hsize_o   = gnt_sel.size;
      s_hwrite_o  = gnt_sel.write;
      s_hparity_o = gnt_sel.parity;
    end else begin
      s_htrans_o  = HTRANS_IDLE;
      s_haddr_o   = hold_q.addr;
      s_hsize_o   = hold_q.size;
      s_hwrite_o  = hold_q.write;
      s_hparity_o = hold_q.parity;
    end
  end

  assign s_hwdata_o     = (owner_q == OWN_D) ? s_d_hwdata_i     : '0;
  assign s_hwchecksum_o = (owner_q == OWN_D) ? s_d_hwchecksum_i : '0;

  assign s_i_hready_o   = i_rdy;
  assign s_d_hready_o   = d_rdy;
  assign s_i_hresp_o    = (owner_q == OWN_I) ? s_hresp_i : 1'b0;
  assign s_d_hresp_o    = (owner_q == OWN_D) ? s_hresp_i : 1'b0;
  assign s_hrdata_o     = s_hrdata_i;
  assign s_hrchecksum_o = s_hrchecksum_i;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: round-robin and fixed-priority instances
// share stimulus; inputs change #1 after posedge, outputs are sampled on negedge.
module tb_ahb_bus_arbiter;

  logic        s_clk_i, s_resetn_i;
  logic [31:0] s_i_haddr_i, s_d_haddr_i, s_d_hwdata_i, s_hrdata_i;
  logic [1:0]  s_i_htrans_i, s_d_htrans_i;
  logic [2:0]  s_i_hsize_i, s_d_hsize_i;
  logic        s_i_hwrite_i, s_d_hwrite_i, s_hready_i, s_hresp_i;
  logic [5:0]  s_i_hparity_i, s_d_hparity_i;
  logic [6:0]  s_d_hwchecksum_i, s_hrchecksum_i;

  logic        rr_i_hready, rr_i_hresp, rr_d_hready, rr_d_hresp, rr_hwrite;
  logic [31:0] rr_hrdata, rr_haddr, rr_hwdata;
  logic [6:0]  rr_hrchecksum, rr_hwchecksum;
  logic [1:0]  rr_htrans;
  logic [2:0]  rr_hsize;
  logic [5:0]  rr_hparity;

  logic        fp_i_hready, fp_i_hresp, fp_d_hready, fp_d_hresp, fp_hwrite;
  logic [31:0] fp_hrdata, fp_haddr, fp_hwdata;
  logic [6:0]  fp_hrchecksum, fp_hwchecksum;
  logic [1:0]  fp_htrans;
  logic [2:0]  fp_hsize;
  logic [5:0]  fp_hparity;

  int n_cmp = 0;
  int n_mis = 0;

  ahb_bus_arbiter #(.RR_ARB(1'b1)) dut_rr (
    .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i),
    .s_i_haddr_i(s_i_haddr_i), .s_i_htrans_i(s_i_htrans_i), .s_i_hsize_i(s_i_hsize_i),
    .s_i_hwrite_i(s_i_hwrite_i), .s_i_hparity_i(s_i_hparity_i),
    .s_d_haddr_i(s_d_haddr_i), .s_d_htrans_i(s_d_htrans_i), .s_d_hsize_i(s_d_hsize_i),
    .s_d_hwrite_i(s_d_hwrite_i), .s_d_hparity_i(s_d_hparity_i),
    .s_d_hwdata_i(s_d_hwdata_i), .s_d_hwchecksum_i(s_d_hwchecksum_i),
    .s_i_hready_o(rr_i_hready), .s_i_hresp_o(rr_i_hresp),
    .s_d_hready_o(rr_d_hready), .s_d_hresp_o(rr_d_hresp),
    .s_hrdata_o(rr_hrdata), .s_hrchecksum_o(rr_hrchecksum),
    .s_haddr_o(rr_haddr), .s_htrans_o(rr_htrans), .s_hsize_o(rr_hsize),
    .s_hwrite_o(rr_hwrite), .s_hparity_o(rr_hparity),
    .s_hwdata_o(rr_hwdata), .s_hwchecksum_o(rr_hwchecksum),
    .s_hrdata_i(s_hrdata_i), .s_hrchecksum_i(s_hrchecksum_i),
    .s_hready_i(s_hready_i), .s_hresp_i(s_hresp_i)
  );

  ahb_bus_arbiter #(.RR_ARB(1'b0)) dut_fp (
    .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i),
    .s_i_haddr_i(s_i_haddr_i), .s_i_htrans_i(s_i_htrans_i), .s_i_hsize_i(s_i_hsize_i),
    .s_i_hwrite_i(s_i_hwrite_i), .s_i_hparity_i(s_i_hparity_i),
    .s_d_haddr_i(s_d_haddr_i), .s_d_htrans_i(s_d_htrans_i), .s_d_hsize_i(s_d_hsize_i),
    .s_d_hwrite_i(s_d_hwrite_i), .s_d_hparity_i(s_d_hparity_i),
    .s_d_hwdata_i(s_d_hwdata_i), .s_d_hwchecksum_i(s_d_hwchecksum_i),
    .s_i_hready_o(fp_i_hready), .s_i_hresp_o(fp_i_hresp),
    .s_d_hready_o(fp_d_hready), .s_d_hresp_o(fp_d_hresp),
    .s_hrdata_o(fp_hrdata), .s_hrchecksum_o(fp_hrchecksum),
    .s_haddr_o(fp_haddr), .s_htrans_o(fp_htrans), .s_hsize_o(fp_hsize),
    .s_hwrite_o(fp_hwrite), .s_hparity_o(fp_hparity),
    .s_hwdata_o(fp_hwdata), .s_hwchecksum_o(fp_hwchecksum),
    .s_hrdata_i(s_hrdata_i), .s_hrchecksum_i(s_hrchecksum_i),
    .s_hready_i(s_hready_i), .s_hresp_i(s_hresp_i)
  );

  initial s_clk_i = 1'b0;
  always #5 s_clk_i = ~s_clk_i;

  task automatic tick();
    @(posedge s_clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    s_i_haddr_i = '0; s_i_htrans_i = 2'b00; s_i_hsize_i = 3'd2; s_i_hwrite_i = 1'b0; s_i_hparity_i = '0;
    s_d_haddr_i = '0; s_d_htrans_i = 2'b00; s_d_hsize_i = 3'd2; s_d_hwrite_i = 1'b0; s_d_hparity_i = '0;
    s_d_hwdata_i = '0; s_d_hwchecksum_i = '0;
    s_hrdata_i = '0; s_hrchecksum_i = '0; s_hready_i = 1'b1; s_hresp_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    s_resetn_i = 1'b0;
    @(negedge s_clk_i);
    s_resetn_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    s_resetn_i = 1'b0;
    #2;
    n_cmp++; if (rr_htrans !== 2'b00) begin n_mis++; $display("FAIL rst_htrans got %b want 00", rr_htrans); end
    n_cmp++; if (rr_haddr !== 32'h0) begin n_mis++; $display("FAIL rst_haddr got %h want 0", rr_haddr); end
    n_cmp++; if ({rr_i_hready, rr_d_hready} !== 2'b11) begin n_mis++; $display("FAIL rst_hready got %b want 11", {rr_i_hready, rr_d_hready}); end
    s_hresp_i = 1'b1;
    #1;
    n_cmp++; if ({rr_i_hresp, rr_d_hresp} !== 2'b00) begin n_mis++; $display("FAIL rst_hresp got %b want 00", {rr_i_hresp, rr_d_hresp}); end
    s_hresp_i = 1'b0;
    @(negedge s_clk_i);
    s_resetn_i = 1'b1;
    tick();
  endtask

  task automatic test_i_read();
    do_reset();
    s_i_haddr_i = 32'h0000_0100; s_i_htrans_i = 2'b10; s_i_hparity_i = 6'h15;
    @(negedge s_clk_i);
    n_cmp++; if (rr_htrans !== 2'b10) begin n_mis++; $display("FAIL iread_htrans got %b want 10", rr_htrans); end
    n_cmp++; if (rr_haddr !== 32'h0000_0100) begin n_mis++; $display("FAIL iread_haddr got %h want 00000100", rr_haddr); end
    n_cmp++; if (rr_i_hready !== 1'b1) begin n_mis++; $display("FAIL iread_hready_a got %b want 1", rr_i_hready); end
    tick();
    s_i_htrans_i = 2'b00; s_hrdata_i = 32'hDEAD_BEEF; s_hrchecksum_i = 7'h3C;
    @(negedge s_clk_i);
    n_cmp++; if (rr_i_hready !== 1'b1) begin n_mis++; $display("FAIL iread_hready_d got %b want 1", rr_i_hready); end
    n_cmp++; if (rr_hrdata !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL iread_hrdata got %h want deadbeef", rr_hrdata); end
    n_cmp++; if (rr_hrchecksum !== 7'h3C) begin n_mis++; $display("FAIL iread_hrchk got %h want 3c", rr_hrchecksum); end
    n_cmp++; if ({rr_htrans, rr_haddr} !== {2'b00, 32'h0000_0100}) begin n_mis++; $display("FAIL iread_hold got %b/%h want 00/00000100", rr_htrans, rr_haddr); end
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    s_i_haddr_i = 32'h200; s_i_htrans_i = 2'b10; s_i_hparity_i = 6'h0A;
    s_d_haddr_i = 32'h300; s_d_htrans_i = 2'b10; s_d_hparity_i = 6'h21; s_d_hwrite_i = 1'b1;
    @(negedge s_clk_i);
    n_cmp++; if ({rr_htrans, rr_haddr, rr_hwrite} !== {2'b10, 32'h300, 1'b1}) begin n_mis++; $display("FAIL cont_n_d got %b/%h/%b want 10/00000300/1", rr_htrans, rr_haddr, rr_hwrite); end
    n_cmp++; if ({rr_i_hready, rr_d_hready} !== 2'b11) begin n_mis++; $display("FAIL cont_n_rdy got %b want 11", {rr_i_hready, rr_d_hready}); end
    tick();
    s_i_htrans_i = 2'b00; s_d_htrans_i = 2'b00; s_d_hwrite_i = 1'b0; s_i_haddr_i = 32'hBAD0; s_i_hparity_i = 6'h3F;
    s_d_hwdata_i = 32'h1234_5678; s_d_hwchecksum_i = 7'h55;
    @(negedge s_clk_i);
    n_cmp++; if ({rr_htrans, rr_haddr, rr_hparity, rr_hwrite} !== {2'b10, 32'h200, 6'h0A, 1'b0}) begin n_mis++; $display("FAIL cont_n1_i got %b/%h/%h/%b want 10/00000200/0a/0", rr_htrans, rr_haddr, rr_hparity, rr_hwrite); end
    n_cmp++; if (rr_i_hready !== 1'b0) begin n_mis++; $display("FAIL cont_n1_irdy got %b want 0", rr_i_hready); end
    n_cmp++; if ({rr_hwdata, rr_hwchecksum} !== {32'h1234_5678, 7'h55}) begin n_mis++; $display("FAIL cont_n1_wdata got %h/%h want 12345678/55", rr_hwdata, rr_hwchecksum); end
    tick();
    @(negedge s_clk_i);
    n_cmp++; if (rr_i_hready !== 1'b1) begin n_mis++; $display("FAIL cont_n2_irdy got %b want 1", rr_i_hready); end
    n_cmp++; if ({rr_htrans, rr_hwdata} !== {2'b00, 32'h0}) begin n_mis++; $display("FAIL cont_n2_idle got %b/%h want 00/00000000", rr_htrans, rr_hwdata); end
    tick();
  endtask

  task automatic test_rr_vs_fixed();
    logic [31:0] exp_rr;
    do_reset();
    s_i_haddr_i = 32'h1000; s_i_htrans_i = 2'b10;
    s_d_haddr_i = 32'h2000; s_d_htrans_i = 2'b10;
    for (int k = 0; k < 4; k++) begin
      exp_rr = (k % 2 == 0) ? 32'h2000 : 32'h1000;
      @(negedge s_clk_i);
      n_cmp++; if ({rr_htrans, rr_haddr} !== {2'b10, exp_rr}) begin n_mis++; $display("FAIL rr_grant%0d got %b/%h want 10/%h", k, rr_htrans, rr_haddr, exp_rr); end
      n_cmp++; if ({fp_htrans, fp_haddr} !== {2'b10, 32'h2000}) begin n_mis++; $display("FAIL fp_grant%0d got %b/%h want 10/00002000", k, fp_htrans, fp_haddr); end
      if (k > 0) begin
        n_cmp++; if (fp_i_hready !== 1'b0) begin n_mis++; $display("FAIL fp_istall%0d got %b want 0", k, fp_i_hready); end
      end
      tick();
    end
    s_i_htrans_i = 2'b00; s_d_htrans_i = 2'b00;
  endtask

  task automatic test_wait_capture();
    int low_cnt;
    do_reset();
    low_cnt = 0;
    s_d_haddr_i = 32'h400; s_d_htrans_i = 2'b10; s_d_hparity_i = 6'h11;
    s_i_haddr_i = 32'h500; s_i_htrans_i = 2'b10; s_i_hparity_i = 6'h2C;
    @(negedge s_clk_i);
    n_cmp++; if ({rr_htrans, rr_haddr} !== {2'b10, 32'h400}) begin n_mis++; $display("FAIL wait_d_issue got %b/%h want 10/00000400", rr_htrans, rr_haddr); end
    tick();
    s_d_htrans_i = 2'b00; s_i_htrans_i = 2'b00; s_i_hparity_i = 6'h00; s_i_haddr_i = 32'hFFFF;
    for (int c = 1; c <= 4; c++) begin
      s_hready_i = (c == 4);
      @(negedge s_clk_i);
      if (rr_i_hready == 1'b0) low_cnt++;
      if (c < 4) begin
        n_cmp++; if (rr_htrans !== 2'b00) begin n_mis++; $display("FAIL wait_idle%0d got %b want 00", c, rr_htrans); end
      end
      tick();
    end
    n_cmp++; if (low_cnt !== 4) begin n_mis++; $display("FAIL wait_low_cycles got %0d want 4", low_cnt); end
    s_i_haddr_i = 32'hAAAA;
    #0;
    @(negedge s_clk_i);
    n_cmp++; if (rr_i_hready !== 1'b1) begin n_mis++; $display("FAIL wait_irdy_after got %b want 1", rr_i_hready); end
    n_cmp++; if ({rr_haddr, rr_hparity} !== {32'h500, 6'h2C}) begin n_mis++; $display("FAIL wait_i_hold got %h/%h want 00000500/2c", rr_haddr, rr_hparity); end
    tick();
  endtask

  task automatic test_i_issue_after_wait();
    do_reset();
    s_d_haddr_i = 32'h440; s_d_htrans_i = 2'b10;
    s_i_haddr_i = 32'h540; s_i_htrans_i = 2'b10; s_i_hparity_i = 6'h2C;
    tick();
    s_d_htrans_i = 2'b00; s_i_htrans_i = 2'b00; s_i_hparity_i = 6'h01; s_hready_i = 1'b0;
    tick(); tick(); tick();
    s_hready_i = 1'b1;
    @(negedge s_clk_i);
    n_cmp++; if ({rr_htrans, rr_haddr, rr_hparity} !== {2'b10, 32'h540, 6'h2C}) begin n_mis++; $display("FAIL wait_i_issue got %b/%h/%h want 10/00000540/2c", rr_htrans, rr_haddr, rr_hparity); end
    tick();
  endtask

  task automatic test_error();
    do_reset();
    s_d_haddr_i = 32'h600; s_d_htrans_i = 2'b10;
    tick();
    s_d_htrans_i = 2'b00; s_hready_i = 1'b0; s_hresp_i = 1'b1;
    @(negedge s_clk_i);
    n_cmp++; if ({rr_d_hresp, rr_d_hready} !== 2'b10) begin n_mis++; $display("FAIL err_c1_d got %b want 10", {rr_d_hresp, rr_d_hready}); end
    n_cmp++; if ({rr_i_hresp, rr_i_hready} !== 2'b01) begin n_mis++; $display("FAIL err_c1_i got %b want 01", {rr_i_hresp, rr_i_hready}); end
    tick();
    s_hready_i = 1'b1;
    @(negedge s_clk_i);
    n_cmp++; if ({rr_d_hresp, rr_d_hready} !== 2'b11) begin n_mis++; $display("FAIL err_c2_d got %b want 11", {rr_d_hresp, rr_d_hready}); end
    n_cmp++; if (rr_i_hresp !== 1'b0) begin n_mis++; $display("FAIL err_c2_i got %b want 0", rr_i_hresp); end
    tick();
    s_hresp_i = 1'b0;
    @(negedge s_clk_i);
    n_cmp++; if (rr_d_hresp !== 1'b0) begin n_mis++; $display("FAIL err_c3_d got %b want 0", rr_d_hresp); end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    s_d_haddr_i = 32'h700; s_d_htrans_i = 2'b10;
    s_i_haddr_i = 32'h800; s_i_htrans_i = 2'b10;
    tick();
    s_d_htrans_i = 2'b00; s_i_htrans_i = 2'b00;
    #1;
    n_cmp++; if ({rr_htrans, rr_haddr, rr_i_hready} !== {2'b10, 32'h800, 1'b0}) begin n_mis++; $display("FAIL mid_pre got %b/%h/%b want 10/00000800/0", rr_htrans, rr_haddr, rr_i_hready); end
    s_resetn_i = 1'b0;
    #1;
    n_cmp++; if ({rr_htrans, rr_haddr} !== {2'b00, 32'h0}) begin n_mis++; $display("FAIL mid_rst_bus got %b/%h want 00/00000000", rr_htrans, rr_haddr); end
    n_cmp++; if ({rr_i_hready, rr_d_hready} !== 2'b11) begin n_mis++; $display("FAIL mid_rst_rdy got %b want 11", {rr_i_hready, rr_d_hready}); end
    @(negedge s_clk_i);
    s_resetn_i = 1'b1;
    tick();
    @(negedge s_clk_i);
    n_cmp++; if ({rr_htrans, rr_i_hready} !== {2'b00, 1'b1}) begin n_mis++; $display("FAIL mid_after got %b/%b want 00/1", rr_htrans, rr_i_hready); end
    tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_contention();
    test_rr_vs_fixed();
    test_wait_capture();
    test_i_issue_after_wait();
    test_error();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Two-to-one AHB-Lite arbiter that merges the core's instruction-fetch bus and load/store bus onto a single AHB-Lite master port, for single-port memory subsystems. It sits between the core top level and the interconnect. It buffers a losing address phase and stalls the losing master with its own `hready`. It also routes the data phase, the response and the protection sidebands back to the owning master. Both upstream masters issue only single NONSEQ transfers.

## Interface
- `RR_ARB`, default 1: 1 = round-robin between I and D; 0 = fixed priority, D over I.
- `s_clk_i` in 1: clock.
- `s_resetn_i` in 1: reset, asynchronous, active-low.
- `s_i_haddr_i`, `s_i_htrans_i`, `s_i_hsize_i`, `s_i_hwrite_i`, `s_i_hparity_i` in 32/2/3/1/6: I-master address phase.
- `s_d_haddr_i`, `s_d_htrans_i`, `s_d_hsize_i`, `s_d_hwrite_i`, `s_d_hparity_i` in 32/2/3/1/6: D-master address phase.
- `s_d_hwdata_i`, `s_d_hwchecksum_i` in 32/7: D-master write data and checksum.
- `s_i_hready_o`, `s_i_hresp_o`, `s_d_hready_o`, `s_d_hresp_o` out 1 each: per-master completion and error.
- `s_hrdata_o`, `s_hrchecksum_o` out 32/7: read data and checksum, broadcast to both masters.
- `s_haddr_o`, `s_htrans_o`, `s_hsize_o`, `s_hwrite_o`, `s_hparity_o` out 32/2/3/1/6: merged address phase.
- `s_hwdata_o`, `s_hwchecksum_o` out 32/7: merged write data.
- `s_hrdata_i`, `s_hrchecksum_i`, `s_hready_i`, `s_hresp_i` in 32/7/1/1: downstream response.

## Operation
- Request: a master requests when `htrans[1]=1` and its `hready_o=1` (fresh address phase), or when its pending slot is valid. SEQ is treated as NONSEQ. BUSY is treated as IDLE.
- Pending slot (one per master): holds addr, size, write and parity, plus a valid bit. A fresh request that is not granted in its cycle is captured. The slot clears in the cycle it is granted. A captured transfer is never cancelled; it is always performed.
- Grant: evaluated only when `s_hready_i=1`. With one requester, that master wins. With two requesters and `RR_ARB=1`, the master other than the last winner wins. With `RR_ARB=0`, D wins.
- Address output: the granted master's slot if valid, otherwise its live inputs. `s_htrans_o`=2'b10 when granted, otherwise 2'b00 with the address fields held at their last value.
- Data-phase owner register: takes values NONE, I or D. It loads the grant result (or NONE) when `s_hready_i=1`.
- Write data: `s_hwdata_o` and `s_hwchecksum_o` come from D when the owner is D, otherwise 0.
- Master `hready_o`:
  - 0 while the master's slot is valid.
  - Else `s_hready_i` when the master is the data-phase owner.
  - Else 1.
- Master `hresp_o`: `s_hresp_i` when the master is the owner, otherwise 0. The two-cycle AHB error response passes through unchanged.
- Reset values:
  - Slots invalid.
  - Owner NONE.
  - Last winner = I, so D wins the first conflict.
  - `s_htrans_o`=00, `s_haddr_o`=0.
  - Both `hready_o`=1, both `hresp_o`=0.

## Timing
- Uncontended transfer: zero added latency. The address path is combinational passthrough.
- Contended transfer: the loser's address phase is issued at the first cycle with `s_hready_i=1` after the winner's. The loser sees one extra `hready_o=0` cycle per cycle it waited.
- Downstream wait states (`s_hready_i=0`): the grant and the owner freeze. New fresh requests from a non-owner master are captured into its slot.
- A winner that issues a new request in the cycle after winning competes against the pending loser. In round-robin mode the loser wins.
- An asynchronous reset in the middle of a transfer drops slots and owner immediately. The downstream transfer is abandoned.

## Structure
- `p_hardisc` gains:
  - `typedef enum logic[1:0] {OWN_NONE, OWN_I, OWN_D} ahb_owner_t`
  - `HTRANS_IDLE` and `HTRANS_NONSEQ` constants
  - `ahb_aphase_t` struct: addr, size, write, parity.
- One sub-module, `ahb_pend_slot`, instantiated twice. It holds the capture register and valid bit, with capture and clear inputs.
- The arbiter holds the grant logic, the owner register and the muxes.

## Test plan
- I-only read of 0x0000_0100, `s_hready_i` always 1 → downstream NONSEQ in the same cycle, `s_i_hready_o`=1 every cycle, and `hrdata` 0xDEADBEEF delivered to I.
- I NONSEQ and D write NONSEQ in the same cycle after reset → D issued at cycle N and I at N+1. `s_i_hready_o`=0 at N+1 and =1 at N+2. D's wdata 0x1234_5678 appears on `s_hwdata_o` at N+1.
- Both masters request continuously with `RR_ARB=1` → grants alternate D, I, D, I. With `RR_ARB=0` → D every time while D requests.
- D is owner and downstream inserts 3 wait states while I issues a fresh request → I is captured. `s_i_hready_o`=0 for 4 cycles, then I's address is issued with its original parity.
- Downstream error on a D transfer → `s_d_hresp_o`=1 for 2 cycles (`hready_o` 0 then 1), and `s_i_hresp_o` stays 0.
- `s_resetn_i` asserted with a valid I slot → slot cleared, `s_htrans_o`=00, both `hready_o`=1 before the next clock edge.
